// File: rtl/program_sequencer.sv
// Steps the instruction ROM from first_addr to last_addr, wrapping past 15.
// Each word is fetched, issued to the ALU, timed by a down-counter and then written back.
module program_sequencer #(
  parameter int          AW        = 4,
  parameter int          WW        = 80,
  parameter logic [15:0] LEGAL_OPS = 16'b0000_0111_0101_1111
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          abort,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] rom_addr,
  input  logic [WW-1:0] rom_word,
  output logic          alu_start,
  output logic [3:0]    alu_opr,
  output logic [63:0]   alu_const,
  output logic          ld_a,
  output logic          ld_b,
  output logic          sel_cnst_a,
  output logic          sel_cnst_b,
  output logic          wr_en,
  output logic [1:0]    wr_addr,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic [AW-1:0] pc
);

  // state   | meaning
  // IDLE    | waiting for run; output registers hold their last values
  // FETCH   | rom_addr = pc, word fields latched at the edge
  // ISSUE   | alu_start pulse for a legal opcode, skip for an illegal one
  // WAIT    | cycle budget counts down to 1
  // WRITE   | register-file write strobe, then next pc or DONE
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] last_q;
  logic [5:0]    cnt;
  logic          skip;
  logic          legal;

  logic [5:0] word_maxclk;
  assign word_maxclk = rom_word[11:6];

  assign legal    = LEGAL_OPS[alu_opr];
  assign rom_addr = pc;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    alu_start = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (run) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (legal) begin
          alu_start = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_WRITE;
        end
      end
      S_WAIT:  if (cnt == 6'd1) state_nxt = S_WRITE;
      S_WRITE: begin
        wr_en     = ~skip;
        state_nxt = (pc == last_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort outranks everything, including a run arriving in IDLE
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      last_q     <= '0;
      cnt        <= '0;
      skip       <= 1'b0;
      illegal    <= 1'b0;
      alu_opr    <= '0;
      alu_const  <= '0;
      wr_addr    <= '0;
      ld_a       <= 1'b0;
      ld_b       <= 1'b0;
      sel_cnst_a <= 1'b0;
      sel_cnst_b <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (run && !abort) begin
            pc      <= first_addr;
            last_q  <= last_addr;
            illegal <= 1'b0;
          end
        end
        S_FETCH: begin
          alu_const  <= rom_word[WW-1:16];
          alu_opr    <= rom_word[15:12];
          wr_addr    <= rom_word[5:4];
          ld_a       <= rom_word[3];
          ld_b       <= rom_word[2];
          sel_cnst_a <= rom_word[1];
          sel_cnst_b <= rom_word[0];
          cnt        <= (word_maxclk == 6'd0) ? 6'd1 : word_maxclk;
        end
        S_ISSUE: begin
          skip <= ~legal;
          if (!legal && !abort) illegal <= 1'b1;
        end
        S_WAIT: cnt <= cnt - 6'd1;
        S_WRITE: begin
          if (!abort && pc != last_q) pc <= pc + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a small ROM image, hand-timed steps,
// and immediate assertions at each observation point.
module tb_program_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        abort;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic [3:0]  rom_addr;
  logic [79:0] rom_word;
  logic        alu_start;
  logic [3:0]  alu_opr;
  logic [63:0] alu_const;
  logic        ld_a, ld_b, sel_cnst_a, sel_cnst_b;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic        busy, done, illegal;
  logic [3:0]  pc;

  logic [79:0] rom [16];
  assign rom_word = rom[rom_addr];

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clock = ~clock;

  program_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rom_addr   (rom_addr),
    .rom_word   (rom_word),
    .alu_start  (alu_start),
    .alu_opr    (alu_opr),
    .alu_const  (alu_const),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .sel_cnst_a (sel_cnst_a),
    .sel_cnst_b (sel_cnst_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .pc         (pc)
  );

  function automatic logic [79:0] mk(input logic [63:0] c, input logic [3:0] opr,
                                     input logic [5:0] maxclk, input logic [1:0] wreg,
                                     input logic [3:0] ctl);
    return {c, opr, maxclk, wreg, ctl};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench in cycle 1 (FETCH) of the new program.
  task automatic start(input logic [3:0] f, input logic [3:0] l);
    first_addr = f;
    last_addr  = l;
    run        = 1'b1;
    tick();
    run = 1'b0;
  endtask

  int exp_pc [4] = '{14, 15, 0, 1};
  int exp_wa [4] = '{1, 3, 0, 2};

  initial begin
    int lat, waits, nw, nd, nb;
    bit seen;

    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0]  = mk(64'd1232,               4'd0,  6'd1,  2'd0, 4'b1010);
    rom[1]  = mk(64'h1111,               4'd3,  6'd3,  2'd2, 4'b0000);
    rom[2]  = mk(64'hDEAD_BEEF_0000_0002, 4'd4,  6'd5,  2'd3, 4'b0101);
    rom[3]  = mk(64'h33,                 4'd8,  6'd2,  2'd1, 4'b0000);
    rom[5]  = mk(64'h55,                 4'd5,  6'd4,  2'd1, 4'b0000);
    rom[6]  = mk(64'h66,                 4'd1,  6'd0,  2'd2, 4'b0000);
    rom[7]  = mk(64'h77,                 4'd9,  6'd38, 2'd3, 4'b1100);
    rom[8]  = mk(64'h88,                 4'd10, 6'd38, 2'd0, 4'b0000);
    rom[14] = mk(64'hEE,                 4'd2,  6'd2,  2'd1, 4'b0000);
    rom[15] = mk(64'hFF,                 4'd6,  6'd1,  2'd3, 4'b0000);

    reset = 1'b1; run = 1'b0; abort = 1'b0; first_addr = '0; last_addr = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_pc", pc, 0);
    check("rst_alu_const", alu_const, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_illegal", illegal, 0);

    // single instruction, word 0
    check("t1_idle_busy", busy, 0);
    start(4'd0, 4'd0);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_rom_addr", rom_addr, 0);
    tick();
    check("t1_c2_alu_start", alu_start, 1);
    check("t1_c2_alu_opr", alu_opr, 0);
    check("t1_c2_alu_const", alu_const, 1232);
    check("t1_c2_ld_a", ld_a, 1);
    check("t1_c2_ld_b", ld_b, 0);
    check("t1_c2_sel_a", sel_cnst_a, 1);
    check("t1_c2_sel_b", sel_cnst_b, 0);
    tick();
    check("t1_c3_alu_start", alu_start, 0);
    check("t1_c3_wr_en", wr_en, 0);
    tick();
    check("t1_c4_wr_en", wr_en, 1);
    check("t1_c4_wr_addr", wr_addr, 0);
    check("t1_c4_done", done, 0);
    tick();
    check("t1_c5_done", done, 1);
    check("t1_c5_busy", busy, 1);
    check("t1_c5_wr_en", wr_en, 0);
    tick();
    check("t1_c6_busy", busy, 0);
    check("t1_c6_done", done, 0);

    // long op, word 7, 38-cycle budget
    start(4'd7, 4'd7);
    tick();
    check("t2_alu_start", alu_start, 1);
    check("t2_alu_opr", alu_opr, 9);
    check("t2_ld_a", ld_a, 1);
    check("t2_ld_b", ld_b, 1);
    check("t2_sel_a", sel_cnst_a, 0);
    check("t2_sel_b", sel_cnst_b, 0);
    lat = 0; waits = 0; seen = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      tick();
      if (wr_en) begin
        lat = k;
        seen = 1;
      end else if (busy && !alu_start && !done) begin
        waits++;
      end
    end
    check("t2_start_to_wr", lat, 39);
    check("t2_wait_cycles", waits, 38);
    check("t2_wr_addr", wr_addr, 3);
    tick();
    check("t2_done", done, 1);
    tick();
    check("t2_idle", busy, 0);

    // wrap-around 14 -> 1
    start(4'd14, 4'd1);
    nw = 0; nd = 0;
    for (int k = 0; k < 80; k++) begin
      if (wr_en) begin
        if (nw < 4) begin
          check($sformatf("t3_pc_%0d", nw), pc, exp_pc[nw]);
          check($sformatf("t3_wa_%0d", nw), wr_addr, exp_wa[nw]);
        end
        nw++;
      end
      if (done) nd++;
      if (!busy) break;
      tick();
    end
    check("t3_writes", nw, 4);
    check("t3_dones", nd, 1);
    check("t3_idle", busy, 0);

    // illegal opcode (word 5) then zero budget (word 6)
    start(4'd5, 4'd6);
    check("t4_c1_pc", pc, 5);
    tick();
    check("t4_c2_alu_start", alu_start, 0);
    check("t4_c2_alu_opr", alu_opr, 5);
    tick();
    check("t4_c3_wr_en", wr_en, 0);
    check("t4_c3_alu_start", alu_start, 0);
    check("t4_c3_illegal", illegal, 1);
    check("t4_c3_busy", busy, 1);
    tick();
    check("t4_c4_pc", pc, 6);
    check("t4_c4_illegal", illegal, 1);
    tick();
    check("t4_c5_alu_start", alu_start, 1);
    tick();
    check("t4_c6_wait_wr_en", wr_en, 0);
    tick();
    check("t4_c7_wr_en", wr_en, 1);
    check("t4_c7_wr_addr", wr_addr, 2);
    tick();
    check("t4_c8_done", done, 1);
    tick();
    check("t4_c9_busy", busy, 0);
    check("t4_c9_illegal", illegal, 1);

    // abort during WAIT of word 8 at cycle 20
    start(4'd8, 4'd8);
    check("t5_illegal_cleared", illegal, 0);
    nw = 0; nd = 0;
    for (int c = 1; c < 20; c++) begin
      nw += int'(wr_en);
      nd += int'(done);
      tick();
    end
    check("t5_c20_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_c21_busy", busy, 0);
    check("t5_c21_wr_en", wr_en, 0);
    check("t5_c21_done", done, 0);
    nb = 0;
    for (int c = 0; c < 45; c++) begin
      nw += int'(wr_en);
      nd += int'(done);
      nb += int'(busy);
      tick();
    end
    check("t5_no_writes", nw, 0);
    check("t5_no_done", nd, 0);
    check("t5_stays_idle", nb, 0);
    check("t5_opr_held", alu_opr, 10);
    check("t5_pc_held", pc, 8);
    run = 1'b1; abort = 1'b1; first_addr = 4'd0; last_addr = 4'd0;
    tick();
    run = 1'b0; abort = 1'b0;
    check("t5_run_abort_idle", busy, 0);
    start(4'd0, 4'd0);
    check("t5_restart_busy", busy, 1);
    tick();
    check("t5_restart_alu_start", alu_start, 1);
    check("t5_restart_alu_opr", alu_opr, 0);
    tick(); tick();
    check("t5_restart_wr_en", wr_en, 1);
    tick();
    check("t5_restart_done", done, 1);
    tick();

    // run while busy is ignored
    start(4'd2, 4'd2);
    check("t6_c1_pc", pc, 2);
    tick(); tick();
    first_addr = 4'd9; last_addr = 4'd9; run = 1'b1;
    tick();
    run = 1'b0;
    check("t6_c4_pc", pc, 2);
    tick(); tick(); tick(); tick();
    check("t6_c8_wr_en", wr_en, 1);
    check("t6_c8_wr_addr", wr_addr, 3);
    check("t6_c8_pc", pc, 2);
    tick();
    check("t6_c9_done", done, 1);
    tick();
    check("t6_c10_busy", busy, 0);

    // reset mid-FETCH
    start(4'd3, 4'd3);
    check("t6_fetch_pc", pc, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_pc", pc, 0);
    check("t6_rst_rom_addr", rom_addr, 0);
    check("t6_rst_alu_opr", alu_opr, 0);
    check("t6_rst_alu_const", alu_const, 0);
    check("t6_rst_wr_addr", wr_addr, 0);
    check("t6_rst_ld_b", ld_b, 0);
    check("t6_rst_sel_b", sel_cnst_b, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_alu_start", alu_start, 0);
    nw = 0; nd = 0; nb = 0;
    for (int c = 0; c < 10; c++) begin
      nw += int'(wr_en);
      nd += int'(done);
      nb += int'(busy);
      tick();
    end
    check("t6_rst_no_writes", nw, 0);
    check("t6_rst_no_done", nd, 0);
    check("t6_rst_idle", nb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
